// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall-vector encodings, stage bit indices and FSM state codes for the mips pipeline.
// Every pipeline register indexes its stall bit with the STALL_* index constants below.
package pipeline_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STALL_IDX_PC    = 0;
    localparam int STALL_IDX_IFID  = 1;
    localparam int STALL_IDX_IDEX  = 2;
    localparam int STALL_IDX_EXMEM = 3;
    localparam int STALL_IDX_MEMWB = 4;
    localparam int STALL_IDX_RSVD  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    // Decode-only stall: holds pc and IF/ID, bubbles ID/EX.
    function automatic logic [STALL_W-1:0] stall_from_id(input logic id_stallreq);
        return id_stallreq ? STALL_ID : STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mc_countdown.sv
// Multi-cycle op countdown: load N-1, decrement on request, flag zero; never wraps below zero.
// Latency: registered count, zero flag combinational from the count. No backpressure.
// Synchronous active-low reset clears the count.
module mc_countdown #(
    parameter int MC_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [MC_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [MC_W-1:0] cnt_q;
    logic [MC_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage mips pipeline; optional perf counter via STALL_PERF_CNT_EN.
// Latency: stall/flush/ex_mc_done combinational from inputs and state; mc_busy, stall_cycles registered.
// Backpressure: multi-cycle ops hold pc..EX/MEM until done; flush_req wins over everything.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int MC_W   = 5,
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_stallreq,
    input  logic               ex_mc_start,
    input  logic [MC_W-1:0]    ex_mc_cycles,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               ex_mc_done,
    output logic               mc_busy,
    output logic [PERF_W-1:0]  stall_cycles
);

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic            cnt_load;
    logic [MC_W-1:0] cnt_load_val;
    logic            cnt_dec;
    logic            cnt_zero;

    mc_countdown #(
        .MC_W (MC_W)
    ) u_mc_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        stall        = STALL_NONE;
        flush        = 1'b0;
        ex_mc_done   = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (flush_req) begin
                        flush = 1'b1;
                    end else if (ex_mc_start) begin
                        if (ex_mc_cycles != '0) begin
                            stall        = STALL_EX;
                            cnt_load     = 1'b1;
                            cnt_load_val = ex_mc_cycles - MC_W'(1);
                            state_d      = ST_MC_WAIT;
                        end else begin
                            // Zero-length op completes in its issue cycle without stalling.
                            ex_mc_done = 1'b1;
                        end
                    end else begin
                        stall = stall_from_id(id_stallreq);
                    end
                end
                ST_MC_WAIT: begin
                    if (flush_req) begin
                        flush   = 1'b1;
                        state_d = ST_RUN;
                    end else if (!cnt_zero) begin
                        stall   = STALL_EX;
                        cnt_dec = 1'b1;
                    end else begin
                        ex_mc_done = 1'b1;
                        stall      = stall_from_id(id_stallreq);
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign mc_busy = (state_q == ST_MC_WAIT);

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[STALL_IDX_PC] && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

`ifndef SYNTHESIS
    mc_start_in_wait_a: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == ST_MC_WAIT && ex_mc_start))
        else $warning("pipeline_ctrl: ex_mc_start ignored while a multi-cycle op is in flight");
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard/op sequences followed by random traffic.
module tb_pipeline_ctrl;

    localparam int MC_W   = 5;
    localparam int PERF_W = 32;

    typedef struct packed {
        logic [5:0]        stall;
        logic              flush;
        logic              done;
        logic              busy;
        logic [PERF_W-1:0] sc;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              id_stallreq = 1'b0;
    logic              ex_mc_start = 1'b0;
    logic [MC_W-1:0]   ex_mc_cycles = '0;
    logic              flush_req = 1'b0;
    logic [5:0]        stall;
    logic              flush;
    logic              ex_mc_done;
    logic              mc_busy;
    logic [PERF_W-1:0] stall_cycles;

    pipeline_ctrl #(.MC_W(MC_W), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .ex_mc_done   (ex_mc_done),
        .mc_busy      (mc_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    obs_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: an op in flight is just "busy until absolute cycle done_at".
    bit              m_busy  = 1'b0;
    longint          m_done_at = 0;
    longint          cyc_no  = 0;
    logic [PERF_W-1:0] m_sc  = '0;

    task automatic drive(input bit r, input bit id, input bit st, input int n, input bit fl);
        obs_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_stallreq  = id;
        ex_mc_start  = st;
        ex_mc_cycles = MC_W'(n);
        flush_req    = fl;
        e       = '0;
        e.busy  = m_busy;
`ifdef STALL_PERF_CNT_EN
        e.sc    = m_sc;
`endif
        if (!r) begin
            m_busy = 1'b0;
        end else if (fl) begin
            e.flush = 1'b1;
            m_busy  = 1'b0;
        end else if (m_busy) begin
            if (cyc_no < m_done_at) begin
                e.stall = 6'b001111;
            end else begin
                e.done  = 1'b1;
                e.stall = id ? 6'b000111 : 6'b000000;
                m_busy  = 1'b0;
            end
        end else if (st) begin
            if (n == 0) begin
                e.done = 1'b1;
            end else begin
                e.stall   = 6'b001111;
                m_busy    = 1'b1;
                m_done_at = cyc_no + n;
            end
        end else begin
            e.stall = id ? 6'b000111 : 6'b000000;
        end
        if (!r) m_sc = '0;
        else if (e.stall[0] && m_sc != '1) m_sc = m_sc + 1'b1;
        cyc_no++;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = sb_q.pop_front();
            a = '{stall: stall, flush: flush, done: ex_mc_done, busy: mc_busy, sc: stall_cycles};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got stall=%b flush=%b done=%b busy=%b sc=%0d, want stall=%b flush=%b done=%b busy=%b sc=%0d",
                         $time, a.stall, a.flush, a.done, a.busy, a.sc,
                         e.stall, e.flush, e.done, e.busy, e.sc);
            end
        end
    end

    initial begin
        // Reset with hazards asserted: outputs must stay quiet.
        drive(0, 1, 0, 0, 1);
        drive(0, 1, 1, 3, 1);
        idle(2);
        // Single-cycle load-use stall.
        drive(1, 1, 0, 0, 0);
        idle(2);
        // N=3 multi-cycle op, then observe counter settle.
        drive(1, 0, 1, 3, 0);
        idle(5);
        // N=5 op aborted by flush two cycles in.
        drive(1, 0, 1, 5, 0);
        idle(1);
        drive(1, 1, 0, 0, 1);
        idle(7);
        // Zero-length op, then a start during an N=4 op that must be ignored.
        drive(1, 1, 1, 0, 0);
        drive(1, 0, 1, 4, 0);
        drive(1, 0, 1, 2, 0);
        drive(1, 1, 0, 0, 0);
        idle(4);
        // Op with id_stallreq held across completion; maximum length op.
        drive(1, 1, 1, 2, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 31, 0);
        idle(33);
        // Mid-op reset drops the op silently.
        drive(1, 0, 1, 6, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        idle(3);
        // Random traffic; starts only issued when the model is idle.
        for (int i = 0; i < 3000; i++) begin
            bit r, id, st, fl;
            int n;
            r  = ($urandom_range(0, 299) != 0);
            fl = ($urandom_range(0, 15) == 0);
            id = ($urandom_range(0, 3) == 0);
            st = !m_busy && ($urandom_range(0, 4) == 0);
            n  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 6));
            drive(r, id, st, n, fl);
        end
        idle(1);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected observations never compared, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
